router_burst_sched: RTL and testbench
=====================================

Name: router_burst_sched

Overview:
Round-robin burst scheduler placed in front of the shared simple_router (4-way, din_en/addr/din). Four requesters offer beats via a valid/ready handshake. The block grants one requester at a time, locks the grant for a burst, and drives the router's din_en/addr/din from registers. A per-destination busy input stalls delivery to a destination that cannot accept.

Parameters:
WIDTH, 32, data width; must match the router's WIDTH.
MAX_BURST, 4, maximum beats per grant (1..15); the grant is released when this count is reached.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  4  per-requester beat valid
req_last  input  4  per-requester last-beat-of-burst flag, qualified by req_valid
req_addr  input  8  requester i destination in bits [2i+1:2i]
req_data  input  4*WIDTH  requester i data in bits [WIDTH*(i+1)-1:WIDTH*i]
req_ready  output  4  per-requester beat accepted this cycle (combinational, at most one bit set)
out_busy  input  4  destination d busy; no beat to d is accepted while out_busy[d]=1
rt_din_en  output  1  to router din_en (registered)
rt_addr  output  2  to router addr (registered)
rt_din  output  WIDTH  to router din (registered)
grant_id  output  2  current or most recent owner (registered)
sched_busy  output  1  1 while in BURST

Behaviour:
- Reset: rst_n low asynchronously forces the following. State IDLE, rr_ptr=0, owner=0, beat_cnt=0, burst_addr=0. Outputs: rt_din_en=0, rt_addr=0, rt_din=0, grant_id=0, sched_busy=0. req_ready=0 while rst_n=0.
- Reset asserted mid-burst aborts the burst. No beat is delivered after reset release until a new grant.
- Beat acceptance: a beat is accepted in cycle t when req_ready[i]=1 && req_valid[i]=1.
- Accepted beat latency: 1 cycle. At edge t+1: rt_din_en=1, rt_din=beat data, rt_addr=destination.
- No accepted beat in cycle t: at edge t+1, rt_din_en=0, rt_din=0, rt_addr=0. The router therefore sees all-zero outputs when idle.
- State IDLE:
  - Candidate i qualifies when req_valid[i]=1 && out_busy[req_addr_i]=0.
  - Search order is rr_ptr, rr_ptr+1, ... mod 4. The first qualifying i gets req_ready[i]=1 and its beat is accepted.
  - On accept: owner=i, grant_id=i, burst_addr=req_addr_i, rr_ptr=i+1 mod 4, beat_cnt=1.
  - If req_last[i]=1 or MAX_BURST=1, remain IDLE. Otherwise go to BURST.
  - No qualifying candidate: req_ready=0, no state change.
- State BURST:
  - Only the owner is considered. req_ready[owner] = req_valid[owner] && !out_busy[burst_addr].
  - req_addr of the owner is ignored; every beat goes to the latched burst_addr.
  - On accept: beat_cnt+1. If req_last[owner]=1 or beat_cnt+1==MAX_BURST, go to IDLE (beat_cnt=0). Otherwise stay in BURST.
  - Owner req_valid low: stay in BURST and wait. No timeout; other requesters stay blocked.
  - out_busy[burst_addr]=1: stall. No beat is lost; the requester holds data per the handshake.
- Return to IDLE: the next arbitration can happen in the very next cycle, so back-to-back bursts are possible with no bubble. rr_ptr guarantees a different requester wins first if it is valid.
- Busy destination in IDLE: a requester targeting a busy destination is skipped, not blocked. A lower-priority requester to a free destination wins. rr_ptr advances only on a grant.
- sched_busy = (state==BURST), registered with state.
- Throughput: max 1 beat/cycle.

Test Plan:
- Reset/idle: rst_n=0, then release, all req_valid=0 for 5 cycles -> rt_din_en=0, rt_din=0, rt_addr=0, req_ready=0 throughout.
- Single beat: req 2 valid, req_last=1, addr=2'b01, data=32'hCC -> req_ready=4'b0100 in that cycle. Next cycle: rt_din_en=1, rt_addr=01, rt_din=32'hCC. Cycle after: rt_din_en=0, state IDLE.
- Round robin: all 4 requesters send single-beat bursts continuously from reset -> grant order 0,1,2,3,0 with one beat per cycle and no idle cycles.
- Burst limit: req 1 holds valid, last=0, addr=2'b11, data 1..6 with MAX_BURST=4 -> data 1..4 delivered on consecutive cycles to addr 11. Then req 3, valid with addr 00, data 32'hAA, is granted before req 1 resumes.
- Busy stall and skip:
  - Mid-burst, out_busy[burst_addr]=1 for 3 cycles -> req_ready=0 and rt_din_en=0 for those cycles. The burst resumes with no lost or duplicated beat.
  - In IDLE, req 0 targets busy destination 2 and req 1 targets free destination 0 -> req 1 granted.
- Async reset mid-burst: rst_n low between clock edges during beat 2 -> outputs zero immediately, sched_busy=0. After release, a fresh grant starts from rr_ptr=0.

Source files
------------

// File: rtl/router_burst_sched.sv
// Round-robin burst scheduler feeding the 4-way simple_router.
// One requester owns the router for up to MAX_BURST beats; a busy destination stalls or is skipped.
module router_burst_sched #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    input  logic [3:0]         req_last,
    input  logic [7:0]         req_addr,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         req_ready,
    input  logic [3:0]         out_busy,
    output logic               rt_din_en,
    output logic [1:0]         rt_addr,
    output logic [WIDTH-1:0]   rt_din,
    output logic [1:0]         grant_id,
    output logic               sched_busy
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t             r_state;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         r_owner;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [1:0]         r_burst_addr;
    logic               r_din_en;
    logic [1:0]         r_addr;
    logic [WIDTH-1:0]   r_din;
    logic [1:0]         r_grant_id;

    logic [3:0]         w_ready;
    logic               w_found;
    logic [1:0]         w_sel;
    logic [1:0]         w_idx;
    logic [1:0]         w_acc_addr;
    logic [WIDTH-1:0]   w_acc_data;
    logic               w_end_burst;

    // Arbitration: rotating search in IDLE, owner-only in BURST.
    always_comb begin
        w_ready = '0;
        w_found = 1'b0;
        w_sel   = r_owner;
        w_idx   = r_rr_ptr;
        if (r_state == S_IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = r_rr_ptr + 2'(k);
                if (!w_found && req_valid[w_idx] && !out_busy[req_addr[{w_idx, 1'b0} +: 2]]) begin
                    w_found = 1'b1;
                    w_sel   = w_idx;
                end
            end
        end else begin
            w_found = req_valid[r_owner] && !out_busy[r_burst_addr];
        end
        if (w_found && rst_n) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr[{w_sel, 1'b0} +: 2] : r_burst_addr;
    assign w_acc_data  = req_data[w_sel*WIDTH +: WIDTH];
    assign w_end_burst = req_last[r_owner] || ((r_beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_beat_cnt   <= '0;
            r_burst_addr <= '0;
            r_din_en     <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_grant_id   <= '0;
        end else begin
            if (w_found) begin
                r_din_en <= 1'b1;
                r_addr   <= w_acc_addr;
                r_din    <= w_acc_data;
                if (r_state == S_IDLE) begin
                    r_owner      <= w_sel;
                    r_grant_id   <= w_sel;
                    r_burst_addr <= w_acc_addr;
                    r_rr_ptr     <= w_sel + 2'd1;
                    r_beat_cnt   <= CNT_W'(1);
                    if (!(req_last[w_sel] || MAX_BURST == 1)) begin
                        r_state <= S_BURST;
                    end
                end else if (w_end_burst) begin
                    r_state    <= S_IDLE;
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
            end else begin
                // Router sees all-zero outputs whenever no beat was accepted.
                r_din_en <= 1'b0;
                r_addr   <= '0;
                r_din    <= '0;
            end
        end
    end

    assign req_ready  = w_ready;
    assign rt_din_en  = r_din_en;
    assign rt_addr    = r_addr;
    assign rt_din     = r_din;
    assign grant_id   = r_grant_id;
    assign sched_busy = (r_state == S_BURST);

endmodule

// File: tb/tb_router_burst_sched.sv
// Bench for router_burst_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_router_burst_sched;

    localparam int WIDTH = 32;
    localparam int MAXB  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         req_valid;
    logic [3:0]         req_last;
    logic [7:0]         req_addr;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_ready;
    logic [3:0]         out_busy;
    logic               rt_din_en;
    logic [1:0]         rt_addr;
    logic [WIDTH-1:0]   rt_din;
    logic [1:0]         grant_id;
    logic               sched_busy;

    router_burst_sched #(.WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .out_busy(out_busy),
        .rt_din_en(rt_din_en), .rt_addr(rt_addr), .rt_din(rt_din),
        .grant_id(grant_id), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: who owns the router, how many beats it has sent, where it points.
    bit         m_burst;
    int         m_owner, m_ptr, m_cnt, m_baddr, m_grant;
    bit         e_en;
    int         e_addr;
    logic [WIDTH-1:0] e_din;
    logic [3:0] last_rdy;
    logic [WIDTH-1:0] got [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_burst = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_baddr = 0; m_grant = 0;
        e_en = 0; e_addr = 0; e_din = '0;
    endtask

    function automatic int dest_of(input int i);
        return int'(req_addr[2*i +: 2]);
    endfunction

    // One clock: check req_ready mid-cycle, predict and check the registered outputs after the edge.
    task automatic step();
        int win;
        @(negedge clk);
        win = -1;
        if (!m_burst) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (win < 0 && req_valid[i] && !out_busy[dest_of(i)]) win = i;
            end
        end else if (req_valid[m_owner] && !out_busy[m_baddr]) begin
            win = m_owner;
        end
        last_rdy = req_ready;
        chk("req_ready", 64'(req_ready), (win >= 0) ? 64'(1 << win) : 64'd0);
        if (win >= 0) begin
            e_en   = 1;
            e_din  = req_data[win*WIDTH +: WIDTH];
            e_addr = m_burst ? m_baddr : dest_of(win);
            if (!m_burst) begin
                m_owner = win; m_grant = win; m_baddr = dest_of(win);
                m_ptr = (win + 1) % 4; m_cnt = 1;
                if (!(req_last[win] || MAXB == 1)) m_burst = 1;
            end else begin
                m_cnt++;
                if (req_last[win] || m_cnt == MAXB) begin
                    m_burst = 0; m_cnt = 0;
                end
            end
        end else begin
            e_en = 0; e_din = '0; e_addr = 0;
        end
        @(posedge clk);
        #1;
        chk("rt_din_en", 64'(rt_din_en), 64'(e_en));
        chk("rt_addr", 64'(rt_addr), 64'(e_addr));
        chk("rt_din", 64'(rt_din), 64'(e_din));
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        chk("sched_busy", 64'(sched_busy), 64'(m_burst));
    endtask

    // Asynchronous reset applied between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_din_en", 64'(rt_din_en), 64'd0);
        chk("rst_din", 64'(rt_din), 64'd0);
        chk("rst_addr", 64'(rt_addr), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_sched_busy", 64'(sched_busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_last = '0; req_addr = '0; req_data = '0; out_busy = '0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        #2;
        do_reset();

        // Idle after reset.
        for (int c = 0; c < 5; c++) step();
        chk("idle_en", 64'(rt_din_en), 64'd0);

        // Single beat from requester 2 to destination 1.
        req_valid = 4'b0100; req_last = 4'b0100; req_addr = 8'b00_01_00_00;
        req_data[2*WIDTH +: WIDTH] = 32'hCC;
        step();
        chk("single_rdy", 64'(last_rdy), 64'b0100);
        chk("single_en", 64'(rt_din_en), 64'd1);
        chk("single_addr", 64'(rt_addr), 64'd1);
        chk("single_din", 64'(rt_din), 64'hCC);
        clear_inputs();
        step();
        chk("single_after_en", 64'(rt_din_en), 64'd0);
        chk("single_after_busy", 64'(sched_busy), 64'd0);

        // Round robin of single-beat bursts from reset.
        #2; do_reset();
        req_valid = 4'hF; req_last = 4'hF; req_addr = 8'b11_10_01_00;
        for (int i = 0; i < 4; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(i + 8'h30);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("rr_order", 64'(grant_id), 64'(c % 4));
            chk("rr_en", 64'(rt_din_en), 64'd1);
        end

        // Burst limit: req 1 capped at MAXB beats, then req 3 before req 1 resumes.
        clear_inputs();
        #2; do_reset();
        d = 32'd1;
        req_valid = 4'b1010; req_last = 4'b1000; req_addr = 8'b00_00_11_00;
        req_data[1*WIDTH +: WIDTH] = d; req_data[3*WIDTH +: WIDTH] = 32'hAA;
        for (int c = 0; c < 6; c++) begin
            step();
            got[c] = rt_din;
            if (last_rdy[1]) begin d++; req_data[1*WIDTH +: WIDTH] = d; end
        end
        chk("burst_b0", 64'(got[0]), 64'd1);
        chk("burst_b3", 64'(got[3]), 64'd4);
        chk("burst_other", 64'(got[4]), 64'hAA);
        chk("burst_resume", 64'(got[5]), 64'd5);

        // Mid-burst stall on a busy destination.
        clear_inputs();
        #2; do_reset();
        req_valid = 4'b0001; req_addr = 8'h02; req_data[WIDTH-1:0] = 32'h10;
        step();
        req_data[WIDTH-1:0] = 32'h11;
        out_busy = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_rdy", 64'(last_rdy), 64'd0);
            chk("stall_en", 64'(rt_din_en), 64'd0);
        end
        out_busy = '0;
        step();
        chk("stall_resume", 64'(rt_din), 64'h11);
        req_data[WIDTH-1:0] = 32'h12; req_last = 4'b0001;
        step();
        chk("stall_last", 64'(rt_din), 64'h12);
        chk("stall_done", 64'(sched_busy), 64'd0);

        // Idle skip of a requester whose destination is busy.
        clear_inputs();
        #2; do_reset();
        req_valid = 4'b0011; req_last = 4'b0011; req_addr = 8'h02; out_busy = 4'b0100;
        step();
        chk("skip_rdy", 64'(last_rdy), 64'b0010);
        chk("skip_grant", 64'(grant_id), 64'd1);

        // Asynchronous reset during beat 2 of a burst.
        clear_inputs();
        #2; do_reset();
        req_valid = 4'b0001; req_addr = 8'h01; req_data[WIDTH-1:0] = 32'h50;
        step();
        req_data[WIDTH-1:0] = 32'h51;
        step();
        chk("abort_busy_before", 64'(sched_busy), 64'd1);
        #2; do_reset();
        req_valid = 4'b0101; req_last = 4'b0101; req_addr = 8'b00_01_00_01;
        step();
        chk("abort_fresh_grant", 64'(grant_id), 64'd0);

        // Randomized traffic; requesters hold a presented beat until it is accepted.
        clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin #2; do_reset(); end
            for (int i = 0; i < 4; i++) begin
                if (last_rdy[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 7);
                    req_last[i]  = ($urandom_range(0, 9) < 3);
                    req_addr[2*i +: 2] = 2'($urandom_range(0, 3));
                    req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            out_busy = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
